linked_list_mfifo: RTL and testbench
====================================

// Module: linked_list_mfifo
// PURPOSE
//  Shared-storage multi-queue FIFO: NUM_FIFOS logical queues share one DEPTH-entry data RAM.
//  Queues and the free pool are singly linked lists through a next-pointer array.
//  Successor to the single-output linked-list FIFO: exposes per-queue occupancy, free count,
//  a registered data_out with valid, and defined handling of illegal requests.
//  Sits between multi-channel producers/consumers and is the DUT of the refinement-proof harness.
// PARAMETERS
//  WIDTH      4                     data word width
//  DEPTH      4                     shared entries; power of two, >=2
//  NUM_FIFOS  2                     logical queues; >=2
//  PTR_WIDTH  $clog2(DEPTH)         entry pointer width (derived)
//  SEL_WIDTH  $clog2(NUM_FIFOS)     queue select width (derived)
// PORTS
//  clk        in   1                        single clock, rising edge
//  rst        in   1                        asynchronous, active-low reset
//  push       in   1                        enqueue request
//  push_sel   in   SEL_WIDTH                target queue for push
//  data_in    in   WIDTH                    push data
//  pop        in   1                        dequeue request
//  pop_sel    in   SEL_WIDTH                source queue for pop
//  data_out   out  WIDTH                    popped word, registered
//  out_vld    out  1                        data_out valid, one-cycle pulse
//  empty      out  NUM_FIFOS                per-queue empty (count==0)
//  full       out  1                        free_count==0
//  count      out  NUM_FIFOS*(PTR_WIDTH+1)  per-queue occupancy; queue q at [q*(PTR_WIDTH+1) +: PTR_WIDTH+1]
//  free_count out  PTR_WIDTH+1              free-pool occupancy
//  err        out  2                        {err_push_full, err_pop_empty}, sticky
// BEHAVIOUR
//  Reset (rst==0, async): free list 0->1->..->DEPTH-1 (head 0, tail DEPTH-1); free_count=DEPTH.
//   All count=0, empty=all 1, full=0, data_out=0, out_vld=0, err=0. Queue heads/tails don't-care.
//   Reset asserted mid-operation aborts in-flight requests; no partial link updates survive.
//  Push (legal: push & ~full): node n=free_head; mem[n]<=data_in; free_head<=next[n].
//   Queue empty: head=tail=n; else next[tail]<=n, tail<=n. count[push_sel]++, free_count--.
//  Pop (legal: pop & ~empty[pop_sel]): h=head[pop_sel]; data_out<=mem[h], out_vld<=1 next cycle.
//   head<=next[h]; h appended to free tail; count[pop_sel]--, free_count++.
//   Latency: data visible the cycle after pop; out_vld=0 when no legal pop.
//  Simultaneous push+pop, different queues: both complete in the same cycle.
//  Simultaneous push+pop, same queue, count==1: popped node leaves; pushed node becomes head and tail.
//   Count unchanged.
//  Free list with free_count==1, push+pop: pushed consumes last free node; freed node becomes free head and tail.
//   free_count stays 1.
//  Push when full is illegal even with simultaneous pop (pop still executes).
//  Pop of empty queue is illegal: no state change, out_vld=0.
//  Illegal requests never corrupt lists or counts. Invariant: sum(count)+free_count==DEPTH every cycle.
//  Counters are PTR_WIDTH+1 bits and never wrap. Pointers index 0..DEPTH-1 only; no null encoding.
// CONFIGURATION
//  LL_ERR_EN defined: illegal push sets err[1], illegal pop sets err[0]; sticky until reset.
//  LL_ERR_EN undefined: err tied to 2'b00; illegal requests still dropped silently.
// STRUCTURE
//  Package ll_pkg:
//   - ptr_t, sel_t, cnt_t typedefs
//   - ERR_PUSH_FULL / ERR_POP_EMPTY bit-index constants
//   - reset free-list init function
//  Sub-module ll_free_list owns free_head, free_tail, free_count, and free-list next-pointer writes.
//   Interface: alloc (returns node) / release (accepts node).
//  Top holds data RAM, per-queue head/tail/count, output register, error logic.
// TESTING
//  1. Reset, then 4 pushes to q0 (data 1,2,3,4) -> full=1, count0=4, free_count=0.
//     4 pops -> data_out 1,2,3,4 each one cycle after its pop; empty[0]=1.
//  2. Interleave: push q0=A, push q1=B, push q0=C; pop q1, q0, q0 -> outputs B, A, C.
//     Invariant holds every cycle.
//  3. q0 holds 1 entry X; same-cycle push q0=Y + pop q0 -> data_out=X, count0 stays 1.
//     Next pop -> Y.
//  4. Full, same-cycle pop q1 + push q0 -> pop executes; push dropped; free_count=1.
//     err=2'b10 with LL_ERR_EN, 2'b00 without.
//  5. Pop empty q1 after reset -> out_vld=0, counts unchanged.
//     err=2'b01 with LL_ERR_EN.
//  6. Assert rst low mid-stream with 3 entries queued -> next cycle all outputs at reset values.
//     Subsequent 4 pushes succeed.

Source files
------------

// File: rtl/ll_pkg.sv
// Shared definitions for linked_list_mfifo: default geometry, pointer/select/count types,
// error-bit indices and the reset-time free-list link function.
package ll_pkg;

  localparam int LL_WIDTH     = 4;
  localparam int LL_DEPTH     = 4;
  localparam int LL_NUM_FIFOS = 2;
  localparam int LL_PTR_W     = $clog2(LL_DEPTH);
  localparam int LL_SEL_W     = $clog2(LL_NUM_FIFOS);

  typedef logic [LL_PTR_W-1:0] ptr_t;
  typedef logic [LL_SEL_W-1:0] sel_t;
  typedef logic [LL_PTR_W:0]   cnt_t;

  localparam int ERR_PUSH_FULL = 1;
  localparam int ERR_POP_EMPTY = 0;

  // Successor of node idx in the reset free list 0->1->..->depth-1; the tail wraps to 0 (unused).
  function automatic int unsigned ll_init_next(input int unsigned idx, input int unsigned depth);
    return (idx + 32'd1 == depth) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/ll_free_list.sv
// Free pool of linked_list_mfifo: owns the shared next-pointer array, free head/tail/count,
// hands out the free head on alloc and appends released nodes at the free tail.
module ll_free_list
  import ll_pkg::*;
#(
  parameter int DEPTH     = LL_DEPTH,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_alloc,
  input  logic                 i_release,
  input  logic [PTR_WIDTH-1:0] i_rel_node,
  input  logic                 i_link_we,
  input  logic [PTR_WIDTH-1:0] i_link_ptr,
  input  logic [PTR_WIDTH-1:0] i_link_node,
  input  logic [PTR_WIDTH-1:0] i_rd_ptr,
  output logic [PTR_WIDTH-1:0] o_rd_next,
  output logic [PTR_WIDTH-1:0] o_alloc_node,
  output logic [PTR_WIDTH:0]   o_free_count,
  output logic                 o_full
);

  localparam int CW = PTR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] r_next [DEPTH];
  logic [PTR_WIDTH-1:0] r_head;
  logic [PTR_WIDTH-1:0] r_tail;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        w_cnt_after_alloc;

  assign w_cnt_after_alloc = r_count - CW'(i_alloc);
  assign o_rd_next         = r_next[i_rd_ptr];
  assign o_alloc_node      = r_head;
  assign o_free_count      = r_count;
  assign o_full            = (r_count == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_next[i] <= PTR_WIDTH'(ll_init_next(i, DEPTH));
      end
      r_head  <= '0;
      r_tail  <= PTR_WIDTH'(DEPTH - 1);
      r_count <= CW'(DEPTH);
    end else begin
      // Queue link and free-tail link never target the same node: one is a queue tail, the other a free node.
      if (i_link_we) begin
        r_next[i_link_ptr] <= i_link_node;
      end
      if (i_release) begin
        if (w_cnt_after_alloc == '0) begin
          r_head <= i_rel_node;
          r_tail <= i_rel_node;
        end else begin
          r_next[r_tail] <= i_rel_node;
          r_tail         <= i_rel_node;
          if (i_alloc) begin
            r_head <= r_next[r_head];
          end
        end
      end else if (i_alloc) begin
        r_head <= r_next[r_head];
      end
      r_count <= w_cnt_after_alloc + CW'(i_release);
    end
  end

endmodule

// File: rtl/linked_list_mfifo.sv
// Multi-queue FIFO sharing one data RAM; queues and free pool are linked lists.
// Optional sticky error flags for illegal push/pop are enabled by defining LL_ERR_EN.
module linked_list_mfifo
  import ll_pkg::*;
#(
  parameter int WIDTH     = LL_WIDTH,
  parameter int DEPTH     = LL_DEPTH,
  parameter int NUM_FIFOS = LL_NUM_FIFOS,
  parameter int PTR_WIDTH = $clog2(DEPTH),
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic [SEL_WIDTH-1:0]                push_sel,
  input  logic [WIDTH-1:0]                    data_in,
  input  logic                                pop,
  input  logic [SEL_WIDTH-1:0]                pop_sel,
  output logic [WIDTH-1:0]                    data_out,
  output logic                                out_vld,
  output logic [NUM_FIFOS-1:0]                empty,
  output logic                                full,
  output logic [NUM_FIFOS*(PTR_WIDTH+1)-1:0]  count,
  output logic [PTR_WIDTH:0]                  free_count,
  output logic [1:0]                          err
);

  localparam int CW = PTR_WIDTH + 1;

  logic [WIDTH-1:0]     r_mem   [DEPTH];
  logic [PTR_WIDTH-1:0] r_head  [NUM_FIFOS];
  logic [PTR_WIDTH-1:0] r_tail  [NUM_FIFOS];
  logic [CW-1:0]        r_count [NUM_FIFOS];
  logic [WIDTH-1:0]     r_data_out;
  logic                 r_out_vld;

  logic                 w_full;
  logic                 w_push_ok;
  logic                 w_pop_ok;
  logic                 w_solo;
  logic                 w_link_we;
  logic [PTR_WIDTH-1:0] w_alloc_node;
  logic [PTR_WIDTH-1:0] w_pop_head;
  logic [PTR_WIDTH-1:0] w_pop_next;
  logic [PTR_WIDTH-1:0] w_push_tail;
  logic [CW-1:0]        w_push_cnt;
  logic [CW-1:0]        w_free_count;
  logic [NUM_FIFOS-1:0] w_empty;
  logic [NUM_FIFOS-1:0] w_push_q;
  logic [NUM_FIFOS-1:0] w_pop_q;

  always_comb begin
    w_empty  = '0;
    w_push_q = '0;
    w_pop_q  = '0;
    count    = '0;
    for (int q = 0; q < NUM_FIFOS; q++) begin
      w_empty[q]          = (r_count[q] == '0);
      count[q*CW +: CW]   = r_count[q];
      w_push_q[q]         = w_push_ok && (push_sel == SEL_WIDTH'(q));
      w_pop_q[q]          = w_pop_ok && (pop_sel == SEL_WIDTH'(q));
    end
  end

  assign w_pop_head  = r_head[pop_sel];
  assign w_push_tail = r_tail[push_sel];
  assign w_push_cnt  = r_count[push_sel];
  assign w_push_ok   = push & ~w_full;
  assign w_pop_ok    = pop & ~w_empty[pop_sel];

  // The pushed node is the whole queue when the queue is empty or its only node leaves this cycle.
  assign w_solo    = (w_push_cnt == '0) |
                     (w_pop_ok & (push_sel == pop_sel) & (w_push_cnt == CW'(1)));
  assign w_link_we = w_push_ok & ~w_solo;

  ll_free_list #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_free_list (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_alloc      (w_push_ok),
    .i_release    (w_pop_ok),
    .i_rel_node   (w_pop_head),
    .i_link_we    (w_link_we),
    .i_link_ptr   (w_push_tail),
    .i_link_node  (w_alloc_node),
    .i_rd_ptr     (w_pop_head),
    .o_rd_next    (w_pop_next),
    .o_alloc_node (w_alloc_node),
    .o_free_count (w_free_count),
    .o_full       (w_full)
  );

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_alloc_node] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int q = 0; q < NUM_FIFOS; q++) begin
        r_head[q]  <= '0;
        r_tail[q]  <= '0;
        r_count[q] <= '0;
      end
      r_data_out <= '0;
      r_out_vld  <= 1'b0;
    end else begin
      r_out_vld <= w_pop_ok;
      if (w_pop_ok) begin
        r_data_out <= r_mem[w_pop_head];
      end
      for (int q = 0; q < NUM_FIFOS; q++) begin
        if (w_pop_q[q]) begin
          r_head[q] <= w_pop_next;
        end
        if (w_push_q[q]) begin
          r_tail[q] <= w_alloc_node;
          if (w_solo) begin
            r_head[q] <= w_alloc_node;
          end
        end
        if (w_push_q[q] && !w_pop_q[q]) begin
          r_count[q] <= r_count[q] + CW'(1);
        end else if (w_pop_q[q] && !w_push_q[q]) begin
          r_count[q] <= r_count[q] - CW'(1);
        end
      end
    end
  end

`ifdef LL_ERR_EN
  logic [1:0] r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 2'b00;
    end else begin
      if (push & w_full) begin
        r_err[ERR_PUSH_FULL] <= 1'b1;
      end
      if (pop & w_empty[pop_sel]) begin
        r_err[ERR_POP_EMPTY] <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 2'b00;
`endif

  assign data_out   = r_data_out;
  assign out_vld    = r_out_vld;
  assign empty      = w_empty;
  assign full       = w_full;
  assign free_count = w_free_count;

endmodule

// File: tb/tb_linked_list_mfifo.sv
// Directed self-checking bench for linked_list_mfifo (default geometry: WIDTH 4, DEPTH 4, 2 queues).
module tb_linked_list_mfifo;

  localparam int W  = 4;
  localparam int SW = 1;

`ifdef LL_ERR_EN
  localparam logic [1:0] EXP_ERR_FULL  = 2'b10;
  localparam logic [1:0] EXP_ERR_EMPTY = 2'b01;
`else
  localparam logic [1:0] EXP_ERR_FULL  = 2'b00;
  localparam logic [1:0] EXP_ERR_EMPTY = 2'b00;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic [SW-1:0] push_sel = '0;
  logic [W-1:0]  data_in = '0;
  logic          pop = 1'b0;
  logic [SW-1:0] pop_sel = '0;
  logic [W-1:0]  data_out;
  logic          out_vld;
  logic [1:0]    empty;
  logic          full;
  logic [5:0]    count;
  logic [2:0]    free_count;
  logic [1:0]    err;

  int n_cmp  = 0;
  int n_fail = 0;

  linked_list_mfifo dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_sel   (push_sel),
    .data_in    (data_in),
    .pop        (pop),
    .pop_sel    (pop_sel),
    .data_out   (data_out),
    .out_vld    (out_vld),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .free_count (free_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [SW-1:0] ps, input logic [W-1:0] d,
                       input logic o, input logic [SW-1:0] os);
    push     = p;
    push_sel = ps;
    data_in  = d;
    pop      = o;
    pop_sel  = os;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({full, empty, free_count, count} !== {1'b0, 2'b11, 3'd4, 6'd0}) begin
      n_fail++;
      $display("FAIL reset_status: got full=%b empty=%b free=%0d count=%h want full=0 empty=11 free=4 count=00",
               full, empty, free_count, count);
    end
    n_cmp++;
    if ({out_vld, data_out, err} !== {1'b0, 4'h0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_out: got vld=%b dout=%h err=%b want vld=0 dout=0 err=00", out_vld, data_out, err);
    end
  endtask

  task automatic test_fill_drain();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, W'(k), 1'b0, 1'b0);
      tick();
      n_cmp++;
      if ({count[2:0], free_count} !== {3'(k), 3'(4 - k)}) begin
        n_fail++;
        $display("FAIL fill_count_%0d: got count0=%0d free=%0d want count0=%0d free=%0d",
                 k, count[2:0], free_count, k, 4 - k);
      end
    end
    idle();
    n_cmp++;
    if ({full, empty} !== {1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL fill_full: got full=%b empty=%b want full=1 empty=10", full, empty);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if ({out_vld, data_out} !== {1'b1, W'(k)}) begin
        n_fail++;
        $display("FAIL drain_data_%0d: got vld=%b dout=%h want vld=1 dout=%h", k, out_vld, data_out, k);
      end
    end
    idle();
    tick();
    n_cmp++;
    if ({out_vld, full, empty, free_count} !== {1'b0, 1'b0, 2'b11, 3'd4}) begin
      n_fail++;
      $display("FAIL drain_end: got vld=%b full=%b empty=%b free=%0d want vld=0 full=0 empty=11 free=4",
               out_vld, full, empty, free_count);
    end
  endtask

  task automatic test_interleave();
    int t_push [6] = '{1, 1, 1, 0, 0, 0};
    int t_psel [6] = '{0, 1, 0, 0, 0, 0};
    int t_din  [6] = '{10, 11, 12, 0, 0, 0};
    int t_pop  [6] = '{0, 0, 0, 1, 1, 1};
    int t_osel [6] = '{0, 0, 0, 1, 0, 0};
    int t_dout [6] = '{0, 0, 0, 11, 10, 12};
    int t_c0   [6] = '{1, 1, 2, 2, 1, 0};
    int t_c1   [6] = '{0, 1, 1, 0, 0, 0};
    int sum;
    for (int i = 0; i < 6; i++) begin
      drive(1'(t_push[i]), SW'(t_psel[i]), W'(t_din[i]), 1'(t_pop[i]), SW'(t_osel[i]));
      tick();
      n_cmp++;
      if ({out_vld, data_out} !== {1'(t_pop[i]), W'(t_dout[i])} && (t_pop[i] == 1 || out_vld !== 1'b0)) begin
        n_fail++;
        $display("FAIL interleave_out_%0d: got vld=%b dout=%h want vld=%0d dout=%h",
                 i, out_vld, data_out, t_pop[i], t_dout[i]);
      end
      n_cmp++;
      if ({count[5:3], count[2:0]} !== {3'(t_c1[i]), 3'(t_c0[i])}) begin
        n_fail++;
        $display("FAIL interleave_count_%0d: got c1=%0d c0=%0d want c1=%0d c0=%0d",
                 i, count[5:3], count[2:0], t_c1[i], t_c0[i]);
      end
      sum = 32'(count[2:0]) + 32'(count[5:3]) + 32'(free_count);
      n_cmp++;
      if (sum !== 4) begin
        n_fail++;
        $display("FAIL interleave_invariant_%0d: got %0d want 4", i, sum);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_same_queue();
    drive(1'b1, 1'b0, 4'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 4'd6, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({out_vld, data_out, count[2:0], free_count} !== {1'b1, 4'd5, 3'd1, 3'd3}) begin
      n_fail++;
      $display("FAIL same_q_swap: got vld=%b dout=%h c0=%0d free=%0d want vld=1 dout=5 c0=1 free=3",
               out_vld, data_out, count[2:0], free_count);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({out_vld, data_out, count[2:0]} !== {1'b1, 4'd6, 3'd0}) begin
      n_fail++;
      $display("FAIL same_q_next: got vld=%b dout=%h c0=%0d want vld=1 dout=6 c0=0", out_vld, data_out, count[2:0]);
    end
    // Last free node: q1 holds 7,8 and q0 holds 1, leaving free_count 1.
    drive(1'b1, 1'b1, 4'd7, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 4'd8, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({out_vld, data_out, count[5:3], count[2:0], free_count} !== {1'b1, 4'd1, 3'd2, 3'd1, 3'd1}) begin
      n_fail++;
      $display("FAIL last_free_swap: got vld=%b dout=%h c1=%0d c0=%0d free=%0d want vld=1 dout=1 c1=2 c0=1 free=1",
               out_vld, data_out, count[5:3], count[2:0], free_count);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0); tick();
    n_cmp++;
    if (data_out !== 4'd2) begin n_fail++; $display("FAIL last_free_q0: got %h want 2", data_out); end
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); tick();
    n_cmp++;
    if (data_out !== 4'd7) begin n_fail++; $display("FAIL last_free_q1a: got %h want 7", data_out); end
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1); tick();
    n_cmp++;
    if (data_out !== 4'd8) begin n_fail++; $display("FAIL last_free_q1b: got %h want 8", data_out); end
    idle();
    tick();
    n_cmp++;
    if ({empty, free_count} !== {2'b11, 3'd4}) begin
      n_fail++;
      $display("FAIL same_q_end: got empty=%b free=%0d want empty=11 free=4", empty, free_count);
    end
  endtask

  task automatic test_full_push_pop();
    drive(1'b1, 1'b0, 4'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'd3, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 4'd4, 1'b0, 1'b0); tick();
    n_cmp++;
    if (full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", full); end
    drive(1'b1, 1'b0, 4'd5, 1'b1, 1'b1);
    tick();
    n_cmp++;
    if ({out_vld, data_out, free_count, count[2:0], count[5:3]} !== {1'b1, 4'd4, 3'd1, 3'd3, 3'd0}) begin
      n_fail++;
      $display("FAIL full_pop_push: got vld=%b dout=%h free=%0d c0=%0d c1=%0d want vld=1 dout=4 free=1 c0=3 c1=0",
               out_vld, data_out, free_count, count[2:0], count[5:3]);
    end
    n_cmp++;
    if (err !== EXP_ERR_FULL) begin n_fail++; $display("FAIL err_push_full: got %b want %b", err, EXP_ERR_FULL); end
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      n_cmp++;
      if ({out_vld, data_out} !== {1'b1, W'(k)}) begin
        n_fail++;
        $display("FAIL full_drain_%0d: got vld=%b dout=%h want vld=1 dout=%h", k, out_vld, data_out, k);
      end
    end
    idle();
    tick();
    n_cmp++;
    if ({empty, free_count, err} !== {2'b11, 3'd4, EXP_ERR_FULL}) begin
      n_fail++;
      $display("FAIL full_end: got empty=%b free=%0d err=%b want empty=11 free=4 err=%b",
               empty, free_count, err, EXP_ERR_FULL);
    end
  endtask

  task automatic test_pop_empty();
    do_reset();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    n_cmp++;
    if ({out_vld, data_out, count, free_count} !== {1'b0, 4'd0, 6'd0, 3'd4}) begin
      n_fail++;
      $display("FAIL pop_empty: got vld=%b dout=%h count=%h free=%0d want vld=0 dout=0 count=00 free=4",
               out_vld, data_out, count, free_count);
    end
    n_cmp++;
    if (err !== EXP_ERR_EMPTY) begin n_fail++; $display("FAIL err_pop_empty: got %b want %b", err, EXP_ERR_EMPTY); end
    idle();
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(1'b1, 1'b0, 4'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, 4'd2, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'd3, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({out_vld, data_out, full, empty, free_count, count, err} !==
        {1'b0, 4'd0, 1'b0, 2'b11, 3'd4, 6'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL mid_reset: got vld=%b dout=%h full=%b empty=%b free=%0d count=%h err=%b want reset values",
               out_vld, data_out, full, empty, free_count, count, err);
    end
    idle();
    rst = 1'b1;
    for (int k = 9; k <= 12; k++) begin
      drive(1'b1, 1'b0, W'(k), 1'b0, 1'b0);
      tick();
    end
    idle();
    n_cmp++;
    if ({full, count[2:0], free_count} !== {1'b1, 3'd4, 3'd0}) begin
      n_fail++;
      $display("FAIL post_reset_fill: got full=%b c0=%0d free=%0d want full=1 c0=4 free=0",
               full, count[2:0], free_count);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if ({out_vld, data_out} !== {1'b1, 4'd9}) begin
      n_fail++;
      $display("FAIL post_reset_pop: got vld=%b dout=%h want vld=1 dout=9", out_vld, data_out);
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_interleave();
    test_same_queue();
    test_full_push_pop();
    test_pop_empty();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
